fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencing controller for the 16x16 synchronous instruction memory (`memoria_instrucoes`). It shares the memory's single port between a program loader (writes) and the processor fetch path (reads). It maintains the program counter, issues reads, and absorbs the memory's one-cycle read latency. Each fetched word is presented to the decode stage through a valid/ready handshake. It sits between the loader/testbench, the memory instance and the processor's decode stage.

## Interface
- ADDR_W, 4: memory address width / PC width
- DATA_W, 16: instruction word width
- RESET_PC, 0: PC value after reset
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- Run  in  1  enable fetching
- Load_valid  in  1  loader requests a write
- Load_addr  in  ADDR_W  loader write address
- Load_data  in  DATA_W  loader write data
- Load_ready  out  1  write accepted this cycle
- Redirect  in  1  load PC with Redirect_pc and discard any in-flight fetch
- Redirect_pc  in  ADDR_W  new PC
- Instr_valid  out  1  Instr/Instr_pc hold a fetched word
- Instr_ready  in  1  decode accepts the word
- Instr  out  DATA_W  fetched instruction
- Instr_pc  out  ADDR_W  address Instr was fetched from
- Mem_address  out  ADDR_W  to memory Address
- Mem_wren  out  1  to memory Wren
- Mem_din  out  DATA_W  to memory Din
- Mem_q  in  DATA_W  from memory Q (valid the cycle after address is sampled)

## Operation
- States:
  - IDLE: the loader owns the port.
  - ISSUE: the read address is driven.
  - WAIT: Mem_q carries mem[pc].
  - HOLD: Instr_valid=1, waiting for decode.
- Combinational outputs:
  - Load_ready = (state==IDLE).
  - Mem_wren = (state==IDLE) & Load_valid.
  - Mem_address = Mem_wren ? Load_addr : pc.
  - Mem_din = Load_data.
- IDLE:
  - If Load_valid: the write happens this cycle and the state stays IDLE. Load wins over Run.
  - Else if Run: go to ISSUE.
- ISSUE → WAIT unconditionally.
- WAIT: at the edge, Instr<=Mem_q, Instr_pc<=pc, pc<=pc+1 (mod 16, so 15 wraps to 0), Instr_valid<=1, then go to HOLD.
- HOLD: Instr, Instr_pc and Instr_valid stay stable while Instr_ready=0. On Instr_valid&Instr_ready: clear Instr_valid, then go to ISSUE if Run, else IDLE.
- Run deasserted in ISSUE/WAIT: the current fetch completes to HOLD, then goes to IDLE after the handshake.
- Redirect (any state): pc<=Redirect_pc.
  - In WAIT or HOLD: clear Instr_valid, then go to ISSUE if Run, else IDLE.
  - In ISSUE: stay in ISSUE and re-issue.
  - In IDLE: only pc changes; a coincident Load_valid write still occurs.
  - If Redirect coincides with a HOLD handshake, the transfer counts and the redirect still applies.
- Mem_q outside WAIT is ignored. This includes the write-through value the memory returns after a write.

## Timing
- Reset (async, Reset=0) forces: state=IDLE, pc=RESET_PC, Instr=0, Instr_pc=0, Instr_valid=0.
  - Combinational outputs follow: Load_ready=1, Mem_address=Load_valid?Load_addr:RESET_PC, Mem_wren=Load_valid.
- Reset mid-operation aborts the fetch immediately. No write is suppressed other than through Load_ready.
- Latency: Run sampled high in IDLE at cycle N gives ISSUE at N+1, WAIT at N+2, and Instr_valid=1 at N+3.
- Throughput with Instr_ready=1: one instruction per 3 cycles.
- Loader throughput: one write per cycle in IDLE.

## Structure
- Shared package: ADDR_W/DATA_W constants, 2-bit state encoding (IDLE=0, ISSUE=1, WAIT=2, HOLD=3), opcode constants (NOP=16'd0, ADD, SUB, LD, ST) for benches.
- Single module with no sub-module; the PC is an inline ADDR_W-bit register.
- Top-level wrapper `fetch_subsystem` instantiates fetch_controller plus the memory. Reset is inverted to the memory's active-high synchronous Reset.

## Test plan
- Reset low, then load addr 0..2 = 16'h4C40, 16'h6000, 16'h8281 → Load_ready=1 and Mem_wren=1 each cycle; reading back gives the same words.
- After load, Run=1, Instr_ready=1 → Instr_valid at +3 cycles with Instr=16'h4C40, Instr_pc=0; the next word arrives 3 cycles later with Instr_pc=1.
- Instr_ready=0 for 5 cycles in HOLD → Instr, Instr_pc and Instr_valid stay constant, Mem_wren=0, and pc is not incremented again.
- Redirect_pc=15 with Run → fetches pc 15, then pc 0 (wrap).
- Redirect_pc=2 asserted in WAIT → that word is never presented; the next Instr_pc=2.
- Reset low during WAIT → Instr_valid=0 and pc=0 immediately. Then Load_valid=1 and Run=1 together in IDLE → write occurs and the state stays IDLE until Load_valid=0.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared constants for the instruction fetch path: widths, FSM encoding and
// opcode values used when building test programs.
package fetch_controller_pkg;
  localparam int FC_ADDR_W = 4;
  localparam int FC_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

  localparam logic [15:0] OP_NOP = 16'h0000;
  localparam logic [15:0] OP_ADD = 16'h4000;
  localparam logic [15:0] OP_SUB = 16'h6000;
  localparam logic [15:0] OP_LD  = 16'h8000;
  localparam logic [15:0] OP_ST  = 16'hA000;
endpackage

// File: rtl/fetch_subsystem.sv
// Fetch controller bound to its instruction memory; the memory takes an
// active-high synchronous reset.
module fetch_subsystem
  import fetch_controller_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Load_valid,
  input  logic [FC_ADDR_W-1:0] Load_addr,
  input  logic [FC_DATA_W-1:0] Load_data,
  output logic                 Load_ready,
  input  logic                 Redirect,
  input  logic [FC_ADDR_W-1:0] Redirect_pc,
  output logic                 Instr_valid,
  input  logic                 Instr_ready,
  output logic [FC_DATA_W-1:0] Instr,
  output logic [FC_ADDR_W-1:0] Instr_pc
);

  logic [FC_ADDR_W-1:0] mem_address;
  logic                 mem_wren;
  logic [FC_DATA_W-1:0] mem_din;
  logic [FC_DATA_W-1:0] mem_q;

  fetch_controller u_fetch (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
    .Load_valid  (Load_valid),
    .Load_addr   (Load_addr),
    .Load_data   (Load_data),
    .Load_ready  (Load_ready),
    .Redirect    (Redirect),
    .Redirect_pc (Redirect_pc),
    .Instr_valid (Instr_valid),
    .Instr_ready (Instr_ready),
    .Instr       (Instr),
    .Instr_pc    (Instr_pc),
    .Mem_address (mem_address),
    .Mem_wren    (mem_wren),
    .Mem_din     (mem_din),
    .Mem_q       (mem_q)
  );

  memoria_instrucoes u_mem (
    .Clock   (Clock),
    .Reset   (~Reset),
    .Address (mem_address),
    .Wren    (mem_wren),
    .Din     (mem_din),
    .Q       (mem_q)
  );

endmodule

// File: rtl/memoria_instrucoes.sv
// 16x16 single-port synchronous instruction memory; Q is registered and
// returns the written data on a write cycle.
module memoria_instrucoes (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Address,
  input  logic        Wren,
  input  logic [15:0] Din,
  output logic [15:0] Q
);

  logic [15:0] mem [16];

  always_ff @(posedge Clock) begin
    if (Wren) mem[Address] <= Din;
  end

  always_ff @(posedge Clock) begin
    if (Reset)     Q <= '0;
    else if (Wren) Q <= Din;
    else           Q <= mem[Address];
  end

endmodule

// File: rtl/fetch_controller.sv
// Shares the single memory port between the program loader and instruction
// fetch; hides the one-cycle read latency behind a valid/ready output.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int          ADDR_W   = FC_ADDR_W,
  parameter int          DATA_W   = FC_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic              Load_valid,
  input  logic [ADDR_W-1:0] Load_addr,
  input  logic [DATA_W-1:0] Load_data,
  output logic              Load_ready,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_pc,
  output logic              Instr_valid,
  input  logic              Instr_ready,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_pc,
  output logic [ADDR_W-1:0] Mem_address,
  output logic              Mem_wren,
  output logic [DATA_W-1:0] Mem_din,
  input  logic [DATA_W-1:0] Mem_q
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;

  assign Load_ready  = (state == S_IDLE);
  assign Mem_wren    = (state == S_IDLE) & Load_valid;
  assign Mem_address = Mem_wren ? Load_addr : pc;
  assign Mem_din     = Load_data;

  assign Instr       = instr_q;
  assign Instr_pc    = instr_pc_q;
  assign Instr_valid = instr_valid_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!Load_valid && Run) state_nxt = S_ISSUE;
      // a redirect during ISSUE simply re-issues at the new pc
      S_ISSUE: if (!Redirect) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = Redirect ? (Run ? S_ISSUE : S_IDLE) : S_HOLD;
      S_HOLD:  if (Redirect || Instr_ready) state_nxt = Run ? S_ISSUE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc            <= ADDR_W'(RESET_PC);
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      if (Redirect)             pc <= Redirect_pc;
      else if (state == S_WAIT) pc <= pc + ADDR_W'(1);
      // Mem_q is only meaningful in WAIT; write-through data is never captured
      if (state == S_WAIT && !Redirect) begin
        instr_q    <= Mem_q;
        instr_pc_q <= pc;
      end
      instr_valid_q <= (state_nxt == S_HOLD);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a behavioural single-port memory
// attached to the Mem_* port.
module tb_fetch_controller;
  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run, Load_valid, Load_ready, Redirect, Instr_valid, Instr_ready;
  logic [3:0]  Load_addr, Redirect_pc, Instr_pc, Mem_address;
  logic [15:0] Load_data, Instr, Mem_din, Mem_q;
  logic        Mem_wren;

  logic [15:0] mem [16];
  logic [15:0] prog [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (Mem_wren) mem[Mem_address] <= Mem_din;
    Mem_q <= Mem_wren ? Mem_din : mem[Mem_address];
  end

  fetch_controller dut (
    .Clock(Clock), .Reset(Reset), .Run(Run),
    .Load_valid(Load_valid), .Load_addr(Load_addr), .Load_data(Load_data),
    .Load_ready(Load_ready), .Redirect(Redirect), .Redirect_pc(Redirect_pc),
    .Instr_valid(Instr_valid), .Instr_ready(Instr_ready), .Instr(Instr),
    .Instr_pc(Instr_pc), .Mem_address(Mem_address), .Mem_wren(Mem_wren),
    .Mem_din(Mem_din), .Mem_q(Mem_q)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0; Run = 0; Load_valid = 0; Load_addr = 0; Load_data = 0;
    Redirect = 0; Redirect_pc = 0; Instr_ready = 0;
    tick(2);
    n_cmp++; if (Instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", Instr_valid); end
    n_cmp++; if (Instr !== 16'h0) begin n_err++; $display("FAIL rst_instr: got %h want 0000", Instr); end
    n_cmp++; if (Instr_pc !== 4'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h want 0", Instr_pc); end
    n_cmp++; if (Load_ready !== 1'b1) begin n_err++; $display("FAIL rst_load_ready: got %b want 1", Load_ready); end
    n_cmp++; if (Mem_wren !== 1'b0 || Mem_address !== 4'h0) begin n_err++; $display("FAIL rst_mem_idle: got wren %b addr %h want 0/0", Mem_wren, Mem_address); end
    Load_valid = 1; Load_addr = 4'h5;
    #1;
    n_cmp++; if (Mem_wren !== 1'b1 || Mem_address !== 4'h5) begin n_err++; $display("FAIL rst_mem_load: got wren %b addr %h want 1/5", Mem_wren, Mem_address); end
    Load_valid = 0;
    #1 Reset = 1'b1;
    tick();
  endtask

  task automatic test_load;
    for (int i = 0; i < 16; i++) begin
      Load_valid = 1; Load_addr = 4'(i); Load_data = prog[i];
      #1;
      n_cmp++;
      if (Load_ready !== 1'b1 || Mem_wren !== 1'b1 || Mem_address !== 4'(i) || Mem_din !== prog[i]) begin
        n_err++; $display("FAIL load_%0d: got rdy %b wren %b addr %h din %h want 1/1/%h/%h",
                          i, Load_ready, Mem_wren, Mem_address, Mem_din, 4'(i), prog[i]);
      end
      tick();
    end
    Load_valid = 0;
  endtask

  task automatic test_fetch;
    Run = 1; Instr_ready = 1;
    tick(1);
    n_cmp++; if (Load_ready !== 1'b0 || Instr_valid !== 1'b0) begin n_err++; $display("FAIL fetch_issue: got rdy %b valid %b want 0/0", Load_ready, Instr_valid); end
    tick(1);
    n_cmp++; if (Instr_valid !== 1'b0) begin n_err++; $display("FAIL fetch_wait: got valid %b want 0", Instr_valid); end
    tick(1);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h4C40 || Instr_pc !== 4'h0) begin n_err++; $display("FAIL fetch_first: got %b %h pc %h want 1 4c40 pc 0", Instr_valid, Instr, Instr_pc); end
    tick(1);
    n_cmp++; if (Instr_valid !== 1'b0) begin n_err++; $display("FAIL fetch_accept: got valid %b want 0", Instr_valid); end
    tick(2);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h6000 || Instr_pc !== 4'h1) begin n_err++; $display("FAIL fetch_second: got %b %h pc %h want 1 6000 pc 1", Instr_valid, Instr, Instr_pc); end
  endtask

  task automatic test_stall;
    Instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (Instr_valid !== 1'b1 || Instr !== 16'h6000 || Instr_pc !== 4'h1 || Mem_wren !== 1'b0 || Mem_address !== 4'h2) begin
        n_err++; $display("FAIL stall_%0d: got %b %h pc %h wren %b addr %h want 1 6000 pc 1 wren 0 addr 2",
                          i, Instr_valid, Instr, Instr_pc, Mem_wren, Mem_address);
      end
    end
    Instr_ready = 1;
    tick(3);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h8281 || Instr_pc !== 4'h2) begin n_err++; $display("FAIL stall_resume: got %b %h pc %h want 1 8281 pc 2", Instr_valid, Instr, Instr_pc); end
  endtask

  task automatic test_wrap;
    // redirect coincides with a HOLD handshake
    Redirect = 1; Redirect_pc = 4'hF;
    tick();
    Redirect = 0;
    n_cmp++; if (Instr_valid !== 1'b0 || Mem_address !== 4'hF) begin n_err++; $display("FAIL wrap_redirect: got valid %b addr %h want 0 f", Instr_valid, Mem_address); end
    tick(2);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h100F || Instr_pc !== 4'hF) begin n_err++; $display("FAIL wrap_pc15: got %b %h pc %h want 1 100f pc f", Instr_valid, Instr, Instr_pc); end
    tick(3);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h4C40 || Instr_pc !== 4'h0) begin n_err++; $display("FAIL wrap_pc0: got %b %h pc %h want 1 4c40 pc 0", Instr_valid, Instr, Instr_pc); end
  endtask

  task automatic test_redirect_wait;
    tick(2);
    Redirect = 1; Redirect_pc = 4'h2;
    tick();
    Redirect = 0;
    n_cmp++; if (Instr_valid !== 1'b0 || Mem_address !== 4'h2) begin n_err++; $display("FAIL redir_wait: got valid %b addr %h want 0 2", Instr_valid, Mem_address); end
    tick();
    n_cmp++; if (Instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_reissue: got valid %b want 0", Instr_valid); end
    tick();
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h8281 || Instr_pc !== 4'h2) begin n_err++; $display("FAIL redir_target: got %b %h pc %h want 1 8281 pc 2", Instr_valid, Instr, Instr_pc); end
  endtask

  task automatic test_reset_mid;
    tick(2);
    #1 Reset = 1'b0;
    #1;
    n_cmp++; if (Instr_valid !== 1'b0 || Mem_address !== 4'h0 || Load_ready !== 1'b1 || Instr !== 16'h0) begin
      n_err++; $display("FAIL mid_reset: got valid %b addr %h rdy %b instr %h want 0 0 1 0000", Instr_valid, Mem_address, Load_ready, Instr);
    end
    #1 Reset = 1'b1;
    Load_valid = 1; Load_addr = 4'h7; Load_data = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Load_ready !== 1'b1 || Mem_wren !== 1'b1) begin n_err++; $display("FAIL load_over_run_%0d: got rdy %b wren %b want 1/1", i, Load_ready, Mem_wren); end
    end
    Load_valid = 0;
    tick();
    n_cmp++; if (Load_ready !== 1'b0) begin n_err++; $display("FAIL run_after_load: got rdy %b want 0", Load_ready); end
    tick(2);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'h4C40 || Instr_pc !== 4'h0) begin n_err++; $display("FAIL post_reset_fetch: got %b %h pc %h want 1 4c40 pc 0", Instr_valid, Instr, Instr_pc); end
    Redirect = 1; Redirect_pc = 4'h7;
    tick();
    Redirect = 0;
    tick(2);
    n_cmp++; if (Instr_valid !== 1'b1 || Instr !== 16'hBEEF || Instr_pc !== 4'h7) begin n_err++; $display("FAIL loaded_word: got %b %h pc %h want 1 beef pc 7", Instr_valid, Instr, Instr_pc); end
    Run = 0;
    tick();
    n_cmp++; if (Load_ready !== 1'b1 || Instr_valid !== 1'b0) begin n_err++; $display("FAIL stop_idle: got rdy %b valid %b want 1 0", Load_ready, Instr_valid); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 16'h1000 | 16'(i);
    prog[0] = 16'h4C40; prog[1] = 16'h6000; prog[2] = 16'h8281;
    test_reset;
    test_load;
    test_fetch;
    test_stall;
    test_wrap;
    test_redirect_wait;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
